link_credit_ctrl: RTL and testbench

- Per-link, multi-channel credit-based flow controller. It sits between the per-port ARQ/link transmitter and the physical link in the fatmeshy top level.
- Tracks downstream buffer credits for NUM_CH channels, for example data and ARQ/control traffic.
- Arbitrates round-robin among channels that are requesting and have credit, and emits a single accepted transfer per cycle.
- Consumes credits on transfer and replenishes them from credit-return messages, in incremental or absolute mode.

---
 rtl/fatmeshy_pkg.sv | 29 ++
 rtl/rr_arbiter.sv | 59 +++++
 rtl/link_credit_ctrl.sv | 142 ++++++++++++++
 tb/tb_link_credit_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fatmeshy_pkg.sv
// Shared types and constants for the fatmeshy link layer: credit widths,
// credit channel indexing and the credit-return interpretation mode.
package fatmeshy_pkg;

  localparam int CREDIT_WIDTH  = 8;
  localparam int NUM_CREDIT_CH = 2;

  typedef logic [CREDIT_WIDTH-1:0] credit_t;

  // Index width for an n-entry channel set; a single channel still needs one bit.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int CREDIT_CH_W = ch_width(NUM_CREDIT_CH);

  typedef logic [CREDIT_CH_W-1:0] credit_ch_t;

  // Incremental: credit_in is a returned count. Absolute: credit_in is the new count.
  typedef enum logic {
    CREDIT_INCR = 1'b0,
    CREDIT_ABS  = 1'b1
  } credit_mode_e;

  function automatic credit_mode_e credit_mode(input bit absolute_mode);
    return absolute_mode ? CREDIT_ABS : CREDIT_INCR;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer.
// The pointer moves past the granted index only when the caller says the
// grant was actually used (advance), so a stalled grant keeps its priority.
module rr_arbiter
  import fatmeshy_pkg::*;
#(
  parameter int N = 2,
  localparam int IW = ch_width(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] ptr_reg;
  logic [IW-1:0] ptr_next;

  // Scan requesters starting at the pointer, wrapping modulo N; first hit wins.
  always_comb begin
    logic [IW:0] pos;
    logic        found;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int k = 0; k < N; k++) begin
      pos = {1'b0, ptr_reg} + (IW+1)'(k);
      if (pos >= (IW+1)'(N)) begin
        pos = pos - (IW+1)'(N);
      end
      if (!found && req[pos[IW-1:0]]) begin
        found              = 1'b1;
        gnt[pos[IW-1:0]]   = 1'b1;
        idx                = pos[IW-1:0];
      end
    end
  end

  // Next pointer: one past the used grant, wrapping at N; otherwise hold.
  always_comb begin
    ptr_next = ptr_reg;
    if (advance) begin
      ptr_next = (idx == IW'(N - 1)) ? '0 : idx + 1'b1;
    end
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg <= '0;
    end else begin
      ptr_reg <= ptr_next;
    end
  end

endmodule

// File: rtl/link_credit_ctrl.sv
// Per-link multi-channel credit flow controller. Each channel keeps a
// downstream buffer credit counter; channels that request and hold credit
// are arbitrated round-robin and at most one transfer is accepted per cycle.
// Returned credits land in the counter at the clock edge, so they become
// usable for a grant one cycle later (no bypass path).
module link_credit_ctrl
  import fatmeshy_pkg::*;
#(
  parameter int NUM_CH        = 2,
  parameter int CREDIT_WIDTH  = fatmeshy_pkg::CREDIT_WIDTH,
  parameter int INIT_CREDIT   = 0,
  parameter int MAX_CREDIT    = (1 << CREDIT_WIDTH) - 1,
  parameter bit ABSOLUTE_MODE = 1'b0,
  localparam int CH_W = ch_width(NUM_CH)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [CREDIT_WIDTH-1:0]        credit_in,
  input  logic [CH_W-1:0]                credit_ch,
  input  logic                           credit_valid,
  input  logic [NUM_CH-1:0]              tx_valid,
  input  logic                           link_ready,
  output logic [NUM_CH-1:0]              tx_accept,
  output logic [CH_W-1:0]                tx_ch,
  output logic [NUM_CH*CREDIT_WIDTH-1:0] credit_count,
  output logic                           credit_err
);

  localparam credit_mode_e                MODE       = credit_mode(ABSOLUTE_MODE);
  localparam logic [CREDIT_WIDTH-1:0]     MAX_C      = CREDIT_WIDTH'(MAX_CREDIT);
  localparam logic [CREDIT_WIDTH:0]       MAX_EXT    = (CREDIT_WIDTH+1)'(MAX_CREDIT);
  localparam logic [CREDIT_WIDTH-1:0]     INIT_C     = CREDIT_WIDTH'(INIT_CREDIT);
  localparam logic [CH_W:0]               NUM_CH_EXT = (CH_W+1)'(NUM_CH);

  logic [NUM_CH-1:0] eligible;
  logic [NUM_CH-1:0] gnt;
  logic [NUM_CH-1:0] err_set;
  logic [CH_W-1:0]   gnt_idx;
  logic              advance;
  logic              bad_ch;
  logic              credit_err_reg;

  // A credit return addressed to a channel that does not exist is dropped
  // and flagged.
  assign bad_ch = credit_valid && ({1'b0, credit_ch} >= NUM_CH_EXT);

  rr_arbiter #(
    .N (NUM_CH)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (eligible),
    .advance (advance),
    .gnt     (gnt),
    .idx     (gnt_idx)
  );

  // The grant only becomes a transfer when the link can take the word;
  // nothing is accepted while reset is held.
  assign tx_accept  = rst ? '0 : (gnt & {NUM_CH{link_ready}});
  assign tx_ch      = gnt_idx;
  assign advance    = |tx_accept;
  assign credit_err = credit_err_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [CREDIT_WIDTH-1:0] count_reg;
      logic [CREDIT_WIDTH-1:0] count_next;
      logic                    err_next;
      logic                    ret;
      logic                    dec;

      assign ret = credit_valid && (credit_ch == CH_W'(gi));
      assign dec = tx_accept[gi];

      // A channel may only win arbitration while it holds credit, which
      // also guarantees a decrement never happens at zero.
      assign eligible[gi] = tx_valid[gi] && (count_reg != '0);

      if (MODE == CREDIT_INCR) begin : g_incr
        // Add returned credits and remove the accepted word in one step,
        // one bit wider so overflow past the ceiling is visible.
        always_comb begin
          logic [CREDIT_WIDTH:0] sum;
          count_next = count_reg;
          err_next   = 1'b0;
          sum = {1'b0, count_reg}
              + (ret ? {1'b0, credit_in} : '0)
              - (CREDIT_WIDTH+1)'(dec);
          if (sum > MAX_EXT) begin
            count_next = MAX_C;
            err_next   = 1'b1;
          end else begin
            count_next = sum[CREDIT_WIDTH-1:0];
          end
        end
      end else begin : g_abs
        // Overwrite with the reported count, less a same-cycle transfer.
        always_comb begin
          count_next = count_reg;
          err_next   = 1'b0;
          if (ret) begin
            if (credit_in > MAX_C) begin
              count_next = MAX_C;
              err_next   = 1'b1;
            end else if ((credit_in == '0) && dec) begin
              count_next = '0;
              err_next   = 1'b1;
            end else begin
              count_next = credit_in - CREDIT_WIDTH'(dec);
            end
          end else begin
            count_next = count_reg - CREDIT_WIDTH'(dec);
          end
        end
      end

      // Credit counter register.
      always_ff @(posedge clk) begin
        if (rst) begin
          count_reg <= INIT_C;
        end else begin
          count_reg <= count_next;
        end
      end

      assign err_set[gi] = err_next;
      assign credit_count[gi*CREDIT_WIDTH +: CREDIT_WIDTH] = count_reg;
    end
  endgenerate

  // Sticky error: any saturation, zero-credit absolute return, or bad channel.
  always_ff @(posedge clk) begin
    if (rst) begin
      credit_err_reg <= 1'b0;
    end else if (bad_ch || (|err_set)) begin
      credit_err_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_link_credit_ctrl.sv
// Bench for link_credit_ctrl: one incremental-mode instance (2 channels)
// and one absolute-mode instance (3 channels, so an out-of-range channel
// index can be driven), both checked every cycle against a behavioural
// model built from counts, a pointer and a sticky error flag.
module tb_link_credit_ctrl;

  localparam int MAXC  = 10;
  localparam int INITC = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A: incremental, NUM_CH=2
  logic [7:0]  a_ci = '0;
  logic        a_ch = '0;
  logic        a_cv = 1'b0;
  logic [1:0]  a_txv = '0;
  logic        a_lr = 1'b0;
  logic [1:0]  a_acc;
  logic        a_txch;
  logic [15:0] a_cnt;
  logic        a_err;

  // Instance B: absolute, NUM_CH=3
  logic [7:0]  b_ci = '0;
  logic [1:0]  b_ch = '0;
  logic        b_cv = 1'b0;
  logic [2:0]  b_txv = '0;
  logic        b_lr = 1'b0;
  logic [2:0]  b_acc;
  logic [1:0]  b_txch;
  logic [23:0] b_cnt;
  logic        b_err;

  link_credit_ctrl #(
    .NUM_CH(2), .CREDIT_WIDTH(8), .INIT_CREDIT(INITC), .MAX_CREDIT(MAXC), .ABSOLUTE_MODE(1'b0)
  ) dut_inc (
    .clk(clk), .rst(rst), .credit_in(a_ci), .credit_ch(a_ch), .credit_valid(a_cv),
    .tx_valid(a_txv), .link_ready(a_lr), .tx_accept(a_acc), .tx_ch(a_txch),
    .credit_count(a_cnt), .credit_err(a_err)
  );

  link_credit_ctrl #(
    .NUM_CH(3), .CREDIT_WIDTH(8), .INIT_CREDIT(INITC), .MAX_CREDIT(MAXC), .ABSOLUTE_MODE(1'b1)
  ) dut_abs (
    .clk(clk), .rst(rst), .credit_in(b_ci), .credit_ch(b_ch), .credit_valid(b_cv),
    .tx_valid(b_txv), .link_ready(b_lr), .tx_accept(b_acc), .tx_ch(b_txch),
    .credit_count(b_cnt), .credit_err(b_err)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Model state and the inputs it last saw, per instance.
  int nch[2]  = '{2, 3};
  bit absm[2] = '{1'b0, 1'b1};
  int m_cnt[2][3];
  int m_ptr[2];
  int m_err[2];
  int m_cv[2];
  int m_ch[2];
  int m_ci[2];
  int m_txv[2];
  int m_lr[2];
  int last_g[2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc%0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  task automatic drive(input int k, input int cv, input int ch, input int ci,
                       input int txv, input int lr);
    m_cv[k] = cv; m_ch[k] = ch; m_ci[k] = ci; m_txv[k] = txv; m_lr[k] = lr;
    if (k == 0) begin
      a_cv = 1'(cv); a_ch = 1'(ch); a_ci = 8'(ci); a_txv = 2'(txv); a_lr = 1'(lr);
    end else begin
      b_cv = 1'(cv); b_ch = 2'(ch); b_ci = 8'(ci); b_txv = 3'(txv); b_lr = 1'(lr);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 3; c++) m_cnt[k][c] = INITC;
      m_ptr[k] = 0;
      m_err[k] = 0;
    end
  endtask

  // Which channel should transfer now: first requester with credit at or
  // after the pointer, provided the link is ready and reset is low.
  function automatic int predict(input int k);
    if (rst || m_lr[k] == 0) return -1;
    for (int j = 0; j < nch[k]; j++) begin
      int c;
      c = (m_ptr[k] + j) % nch[k];
      if (((m_txv[k] >> c) & 1) == 1 && m_cnt[k][c] > 0) return c;
    end
    return -1;
  endfunction

  task automatic model_clock(input int k, input int g);
    int s;
    if (g >= 0) m_ptr[k] = (g + 1) % nch[k];
    if (m_cv[k] != 0 && m_ch[k] >= nch[k]) m_err[k] = 1;
    for (int c = 0; c < nch[k]; c++) begin
      int dec;
      bit ret;
      dec = (g == c) ? 1 : 0;
      ret = (m_cv[k] != 0) && (m_ch[k] == c);
      if (!absm[k]) begin
        s = m_cnt[k][c] + (ret ? m_ci[k] : 0) - dec;
        if (s > MAXC) begin m_cnt[k][c] = MAXC; m_err[k] = 1; end
        else m_cnt[k][c] = s;
      end else if (ret) begin
        if (m_ci[k] > MAXC) begin m_cnt[k][c] = MAXC; m_err[k] = 1; end
        else if (m_ci[k] == 0 && dec == 1) begin m_cnt[k][c] = 0; m_err[k] = 1; end
        else m_cnt[k][c] = m_ci[k] - dec;
      end else begin
        m_cnt[k][c] = m_cnt[k][c] - dec;
      end
    end
  endtask

  function automatic logic [31:0] dut_cnt(input int k, input int c);
    if (k == 0) return 32'(a_cnt[c*8 +: 8]);
    return 32'(b_cnt[c*8 +: 8]);
  endfunction

  // Settle, then compare both instances against the model.
  task automatic sample();
    #1;
    for (int k = 0; k < 2; k++) begin
      int g;
      string nm;
      logic [31:0] got_acc, got_ch, got_err;
      nm = (k == 0) ? "inc" : "abs";
      g = predict(k);
      last_g[k] = g;
      got_acc = (k == 0) ? 32'(a_acc)  : 32'(b_acc);
      got_ch  = (k == 0) ? 32'(a_txch) : 32'(b_txch);
      got_err = (k == 0) ? 32'(a_err)  : 32'(b_err);
      chk({nm, "_accept"}, got_acc, (g >= 0) ? (32'd1 << g) : 32'd0);
      if (g >= 0) begin
        chk({nm, "_tx_ch"}, got_ch, 32'(g));
        $display("xfer %s cyc=%0d ch=%0d credits_before=%0d", nm, cyc, g, m_cnt[k][g]);
      end
      for (int c = 0; c < nch[k]; c++) begin
        chk($sformatf("%s_count%0d", nm, c), dut_cnt(k, c), 32'(m_cnt[k][c]));
      end
      chk({nm, "_err"}, got_err, 32'(m_err[k]));
    end
  endtask

  task automatic tick();
    if (rst) model_reset();
    else for (int k = 0; k < 2; k++) model_clock(k, last_g[k]);
    @(negedge clk);
    cyc++;
  endtask

  task automatic step();
    sample();
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    step();
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    step();
    rst = 1'b0;

    // Reset credits drain: 2,1,0 with two accepts then none.
    drive(0, 0, 0, 0, 1, 1);
    drive(1, 0, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("t1_accept", 32'(a_acc), (i < 2) ? 32'd1 : 32'd0);
      chk("t1_count0", 32'(a_cnt[7:0]), 32'(2 - i));
      tick();
    end

    // Returned credit is visible one cycle later.
    drive(0, 1, 0, 3, 1, 1);
    drive(1, 1, 0, 3, 1, 1);
    sample();
    chk("t2_no_bypass", 32'(a_acc), 32'd0);
    tick();
    drive(0, 0, 0, 0, 1, 1);
    drive(1, 0, 0, 0, 1, 1);
    sample();
    chk("t2_accept", 32'(a_acc), 32'd1);
    chk("t2_count_n1", 32'(a_cnt[7:0]), 32'd3);
    tick();
    sample();
    chk("t2_count_n2", 32'(a_cnt[7:0]), 32'd2);
    tick();

    // Round-robin alternation with a link stall in the middle.
    do_reset();
    drive(0, 1, 0, 2, 0, 1);
    drive(1, 1, 0, 4, 0, 1);
    step();
    drive(0, 1, 1, 2, 0, 1);
    drive(1, 1, 1, 4, 0, 1);
    step();
    for (int i = 0; i < 5; i++) begin
      int lr;
      logic [31:0] exp_acc [5];
      exp_acc = '{32'd1, 32'd2, 32'd0, 32'd1, 32'd2};
      lr = (i == 2) ? 0 : 1;
      drive(0, 0, 0, 0, 3, lr);
      drive(1, 0, 0, 0, 3, lr);
      sample();
      chk("t3_accept", 32'(a_acc), exp_acc[i]);
      if (lr == 1) chk("t3_tx_ch", 32'(a_txch), (exp_acc[i] == 32'd2) ? 32'd1 : 32'd0);
      tick();
    end

    // Incremental saturation sets a sticky error.
    do_reset();
    drive(0, 1, 1, 6, 0, 1);
    step();
    drive(0, 1, 1, 5, 0, 1);
    step();
    drive(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("t4_count1", 32'(a_cnt[15:8]), 32'd10);
      chk("t4_err_sticky", 32'(a_err), 32'd1);
      tick();
    end

    // Absolute mode: overwrite with same-cycle accept, then zero with accept.
    do_reset();
    drive(1, 1, 0, 5, 0, 1);
    step();
    drive(1, 1, 0, 7, 1, 1);
    sample();
    chk("t5_accept", 32'(b_acc), 32'd1);
    tick();
    drive(1, 1, 0, 0, 1, 1);
    sample();
    chk("t5_count_abs", 32'(b_cnt[7:0]), 32'd6);
    tick();
    drive(1, 0, 0, 0, 0, 1);
    sample();
    chk("t5_count_zero", 32'(b_cnt[7:0]), 32'd0);
    chk("t5_err", 32'(b_err), 32'd1);
    tick();

    // Reset mid-stream with both channels requesting.
    do_reset();
    drive(0, 1, 0, 1, 0, 1);
    step();
    drive(0, 1, 1, 5, 3, 1);
    step();
    drive(0, 0, 0, 0, 3, 1);
    step();
    rst = 1'b1;
    drive(1, 0, 0, 0, 7, 1);
    sample();
    chk("t6_accept_in_rst", 32'(a_acc), 32'd0);
    tick();
    rst = 1'b0;
    sample();
    chk("t6_count0", 32'(a_cnt[7:0]), 32'(INITC));
    chk("t6_count1", 32'(a_cnt[15:8]), 32'(INITC));
    chk("t6_first_grant", 32'(a_acc), 32'd1);
    tick();

    // Randomized traffic with occasional resets and bad channel indices.
    for (int i = 0; i < 500; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      for (int k = 0; k < 2; k++) begin
        int cv, ch, ci, txv, lr;
        cv  = ($urandom_range(0, 2) == 0) ? 1 : 0;
        if (k == 0) ch = $urandom_range(0, 1);
        else ch = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
        ci  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3);
        txv = $urandom_range(0, (k == 0) ? 3 : 7);
        lr  = ($urandom_range(0, 3) != 0) ? 1 : 0;
        drive(k, cv, ch, ci, txv, lr);
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
